// File: rtl/incrementer_pkg.sv
// Shared types and constants for the board-level up-counter and its BCD display path.
package incrementer_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} bcd_state_t;

  localparam int MAX_WIDTH = 9;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g..a} patterns, entry 0 in the least significant slot
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [11:0] dabble_adjust(input logic [11:0] acc);
    logic [11:0] res;
    for (int i = 0; i < 3; i++) begin
      res[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, three BCD digits out.
// state | meaning
// IDLE  | waiting for start; accumulator holds last result
// SHIFT | adjust-and-shift, WIDTH cycles, counted down by bit_cnt
// LATCH | result valid for one cycle (done); may restart directly on start
module bin2bcd_seq
  import incrementer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd
);

  bcd_state_t       state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [11:0]      acc, acc_adj;
  logic [3:0]       bit_cnt;
  logic             load, last;

  assign last    = (bit_cnt == 4'd0);
  assign acc_adj = dabble_adjust(acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (last) state_nxt = LATCH;
      end
      LATCH: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      acc     <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= bin;
      acc     <= '0;
      bit_cnt <= 4'(WIDTH - 1);
    end else if (state == SHIFT) begin
      // top adjust bit falls off: a three-digit result never needs it
      {acc, shreg} <= {acc_adj, shreg} << 1;
      if (!last) bit_cnt <= bit_cnt - 4'd1;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == LATCH);
  assign bcd  = acc;

endmodule

// File: rtl/seven_segment_display.sv
// Single-digit BCD to active-low seven-segment decoder.
module seven_segment_display
  import incrementer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = (digit <= 4'd9) ? SEG_TABLE[digit] : SEG_BLANK;

endmodule

// File: rtl/incrementer_fpga.sv
// Board-level up-counter: debounced keys drive count/mode/overflow, shown on three
// seven-segment digits through a multi-cycle binary-to-BCD conversion.
module incrementer_fpga
  import incrementer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           key,
  input  logic [MAX_WIDTH-1:0] sw,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic [1:0]           ledr
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [3:0]       key_s1, key_s2, key_s3, press;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             ovf_q, ovf_nxt, mode_q, chg_q, pending_q;
  logic             bcd_busy, bcd_done;
  logic [11:0]      bcd, disp_q;
  logic [6:0]       seg0, seg1, seg2;

  // key_s3 is only the previous synchronized level for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
      key_s3 <= '1;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  assign press = key_s3 & ~key_s2;

  always_comb begin
    count_nxt = count_q;
    ovf_nxt   = ovf_q;
    if (press[3]) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (press[1]) begin
      count_nxt = sw[WIDTH-1:0];
      ovf_nxt   = 1'b0;
    end else if (press[0]) begin
      if (count_q == COUNT_MAX) begin
        ovf_nxt = 1'b1;
        if (!mode_q) count_nxt = '0;
      end else begin
        count_nxt = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
      chg_q   <= (count_nxt != count_q);
      if (press[2]) mode_q <= ~mode_q;
    end
  end

  bin2bcd_seq #(.WIDTH(WIDTH)) u_bcd (
    .clk   (clk),
    .rst_n (reset),
    .start (chg_q | pending_q),
    .bin   (count_q),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // A change seen in LATCH restarts directly via start, so only SHIFT needs remembering
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
      disp_q    <= '0;
    end else begin
      if (bcd_done)              pending_q <= 1'b0;
      else if (chg_q && bcd_busy) pending_q <= 1'b1;
      if (bcd_done) disp_q <= bcd;
    end
  end

  seven_segment_display u_seg0 (.digit(disp_q[3:0]),  .seg(seg0));
  seven_segment_display u_seg1 (.digit(disp_q[7:4]),  .seg(seg1));
  seven_segment_display u_seg2 (.digit(disp_q[11:8]), .seg(seg2));

  assign hex0 = seg0;
  assign hex1 = (disp_q[11:4] == 8'd0) ? SEG_BLANK : seg1;
  assign hex2 = (disp_q[11:8] == 4'd0) ? SEG_BLANK : seg2;
  assign ledr = {mode_q, ovf_q};

  generate
    if (WIDTH < MAX_WIDTH) begin : g_sw_spare
      logic unused_sw;
      assign unused_sw = ^sw[MAX_WIDTH-1:WIDTH];
    end
  endgenerate

endmodule
